// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: receive frame sequencer.
//
// Walks one burst through these phases:
//   IDLE -> AGC settle -> correlation SEARCH -> DELAY -> payload STORE -> DONE
// The AGC phase is optional. DONE re-arms straight into SEARCH while i_start
// stays high. Dropping i_start aborts the frame from any active phase.
//
// Ports:
//   i_clk        sample-domain clock; the only clock in the block
//   i_rst        synchronous active-high reset
//   i_start      level enable; a rising edge arms, a low level aborts
//   i_agc_en_n   0 = run the AGC settle phase, 1 = skip it
//   i_thresh     unsigned correlation detect threshold
//   i_corr_mag   unsigned correlator magnitude
//   i_corr_vld   qualifier for i_corr_mag
//   i_sym_vld    ADC sample strobe; every phase counter counts this strobe
//   i_store_dly  valid samples to skip between detect and store
//   o_agc_en     AGC loop enable
//   o_corr_arm   correlator search enable
//   o_store_en   payload capture enable
//   o_state      current state code
//   o_busy       high in every state except IDLE
//   o_done       one-cycle pulse when a frame completes
//   o_timeout    one-cycle pulse when a search gives up
//   o_frame_cnt  count of completed frames, wraps modulo 2^16
module rx_frame_ctrl #(
  parameter int PAY_SYMS   = 10000,
  parameter int AGC_SETTLE = 256,
  parameter int TIMEOUT    = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_agc_en_n,
  input  logic [31:0] i_thresh,
  input  logic [31:0] i_corr_mag,
  input  logic        i_corr_vld,
  input  logic        i_sym_vld,
  input  logic [7:0]  i_store_dly,
  output logic        o_agc_en,
  output logic        o_corr_arm,
  output logic        o_store_en,
  output logic [2:0]  o_state,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [15:0] o_frame_cnt
);

  // One counter is shared by all phases. The DELAY phase counts up to an
  // 8-bit delay, so the counter must also hold at least 255.
  localparam int MAX_AB  = (PAY_SYMS > AGC_SETTLE) ? PAY_SYMS : AGC_SETTLE;
  localparam int MAX_ABC = (MAX_AB > TIMEOUT) ? MAX_AB : TIMEOUT;
  localparam int MAX_CNT = (MAX_ABC > 255) ? MAX_ABC : 255;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AGC    = 3'd1,
    S_SEARCH = 3'd2,
    S_DELAY  = 3'd3,
    S_STORE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    dly_q;
  logic [7:0]    dly_nxt;
  logic [15:0]   frame_cnt;
  logic [15:0]   frame_nxt;
  logic          start_q;
  logic          start_edge;
  logic          detect;
  logic          timeout_nxt;

  assign start_edge  = i_start & ~start_q;
  assign detect      = i_corr_vld & (i_corr_mag > i_thresh);
  assign cnt_inc     = cnt + CW'(1);
  assign o_state     = state;
  assign o_frame_cnt = frame_cnt;

  // Next-state logic. Abort is tested before anything else in each active
  // state. In SEARCH, detect is tested before the timeout so that it wins
  // when both happen in the same cycle. Each transition clears the counter.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dly_nxt     = dly_q;
    frame_nxt   = frame_cnt;
    timeout_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (start_edge)
          state_nxt = i_agc_en_n ? S_SEARCH : S_AGC;
      end
      S_AGC: begin
        if (!i_start) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (i_sym_vld) begin
          if (cnt_inc == CW'(AGC_SETTLE)) begin
            state_nxt = S_SEARCH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      S_SEARCH: begin
        if (!i_start) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (detect) begin
          dly_nxt   = i_store_dly;
          state_nxt = (i_store_dly == 8'd0) ? S_STORE : S_DELAY;
          cnt_nxt   = '0;
        end else if (i_sym_vld) begin
          if (cnt_inc == CW'(TIMEOUT)) begin
            state_nxt   = S_IDLE;
            cnt_nxt     = '0;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      S_DELAY: begin
        if (!i_start) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (i_sym_vld) begin
          if (cnt_inc == CW'(dly_q)) begin
            state_nxt = S_STORE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      S_STORE: begin
        if (!i_start) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (i_sym_vld) begin
          if (cnt_inc == CW'(PAY_SYMS)) begin
            state_nxt = S_DONE;
            cnt_nxt   = '0;
            frame_nxt = frame_cnt + 16'd1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      S_DONE: begin
        cnt_nxt   = '0;
        state_nxt = i_start ? S_SEARCH : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters and registered output decodes. The outputs are decoded
  // from the next state, so they change on the same edge as o_state.
  // start_q resets high: an i_start held high through reset must drop and
  // rise again before the block arms.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dly_q      <= 8'd0;
      frame_cnt  <= 16'd0;
      start_q    <= 1'b1;
      o_agc_en   <= 1'b0;
      o_corr_arm <= 1'b0;
      o_store_en <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dly_q      <= dly_nxt;
      frame_cnt  <= frame_nxt;
      start_q    <= i_start;
      o_agc_en   <= ~i_agc_en_n &
                    (state_nxt inside {S_AGC, S_SEARCH, S_DELAY, S_STORE});
      o_corr_arm <= (state_nxt == S_SEARCH);
      o_store_en <= (state_nxt == S_STORE);
      o_busy     <= (state_nxt != S_IDLE);
      o_done     <= (state_nxt == S_DONE);
      o_timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: self-checking bench for rx_frame_ctrl, built with
// PAY_SYMS=8, AGC_SETTLE=4 and TIMEOUT=20. i_sym_vld toggles on every cycle.
//
// A table of whole-frame scenarios gives the inputs and the expected
// per-phase sample counts. Directed sequences cover these cases:
//   - reset
//   - frame-counter wrap with re-arm from DONE
//   - abort during STORE
//   - detect in the same cycle as the timeout
//   - reset during DELAY with i_start held high
module tb_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        agc_n;
  logic [31:0] thr;
  logic [31:0] mag;
  logic        corr_vld;
  logic        sym_vld;
  logic [7:0]  dly;
  logic        agc_en;
  logic        corr_arm;
  logic        store_en;
  logic [2:0]  state;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  // Statistics that applyStimulus() collects. cnt[s] is the number of valid
  // samples consumed while in state s.
  int          cnt [8];
  int          store_en_syms;
  int          n_done;
  int          n_timeout;
  logic [7:0]  mask;
  logic        agc_seen;

  typedef struct {
    logic        agc_n;
    logic [31:0] mag;
    logic [31:0] thr;
    logic [7:0]  dly;
    logic [7:0]  exp_mask;
    int          exp_agc;
    int          exp_search;
    int          exp_delay;
    int          exp_store;
    int          exp_done;
    int          exp_to;
    int          exp_fc;
    logic        exp_agc_en;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  rx_frame_ctrl #(
    .PAY_SYMS   (8),
    .AGC_SETTLE (4),
    .TIMEOUT    (20)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_agc_en_n  (agc_n),
    .i_thresh    (thr),
    .i_corr_mag  (mag),
    .i_corr_vld  (corr_vld),
    .i_sym_vld   (sym_vld),
    .i_store_dly (dly),
    .o_agc_en    (agc_en),
    .o_corr_arm  (corr_arm),
    .o_store_en  (store_en),
    .o_state     (state),
    .o_busy      (busy),
    .o_done      (done),
    .o_timeout   (timeout),
    .o_frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearStats();
    for (int s = 0; s < 8; s++) cnt[s] = 0;
    store_en_syms = 0;
    n_done        = 0;
    n_timeout     = 0;
    mask          = 8'h00;
    if (!$isunknown(state)) mask[state] = 1'b1;
    agc_seen      = 1'b0;
  endtask

  // Runs one clock cycle. The valid sample about to be clocked is credited
  // to the current state. The outputs are sampled 1 time unit after the
  // edge, and then the strobe toggles.
  task automatic applyStimulus();
    if (!$isunknown(state) && sym_vld) begin
      cnt[state]++;
      if (store_en) store_en_syms++;
    end
    @(posedge clk);
    #1;
    sym_vld   = ~sym_vld;
    n_done    += int'(done);
    n_timeout += int'(timeout);
    if (!$isunknown(state)) mask[state] = 1'b1;
    agc_seen  |= agc_en;
  endtask

  task automatic waitState(input logic [2:0] target, input int budget, input string name);
    int n = 0;
    while (state !== target && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput(name, {29'd0, state}, {29'd0, target});
  endtask

  initial begin
    logic [15:0] fc0;
    bit          finished;

    //             agc_n mag           thr           dly   mask   agc srch dly sto done to fc agc_en
    vecs[0] = '{1'b0, 32'd300,      32'd200,      8'd2, 8'h3F, 4, 2,  2,  8, 1,   0, 1, 1'b1};
    vecs[1] = '{1'b0, 32'd200,      32'd200,      8'd2, 8'h07, 4, 20, 0,  0, 0,   1, 0, 1'b1};
    vecs[2] = '{1'b1, 32'd300,      32'd200,      8'd0, 8'h35, 0, 2,  0,  8, 1,   0, 1, 1'b0};
    vecs[3] = '{1'b1, 32'd201,      32'd200,      8'd3, 8'h3D, 0, 2,  3,  8, 1,   0, 1, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd1, 8'h3D, 0, 2,  1,  8, 1,   0, 1, 1'b0};
    vecs[5] = '{1'b0, 32'd0,        32'd0,        8'd1, 8'h07, 4, 20, 0,  0, 0,   1, 0, 1'b1};

    rst = 1'b1; start = 1'b0; agc_n = 1'b0; thr = 32'd200; mag = 32'd0;
    corr_vld = 1'b0; sym_vld = 1'b0; dly = 8'd0;
    clearStats();

    // Reset state
    applyStimulus();
    applyStimulus();
    checkOutput("rst_state", {29'd0, state}, 32'd0);
    checkOutput("rst_flags", {26'd0, agc_en, corr_arm, store_en, busy, done, timeout}, 32'd0);
    checkOutput("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b0;
    applyStimulus();

    // Frame-counter wrap with re-arm from DONE while i_start stays high
    force dut.frame_cnt = 16'hFFFE;
    applyStimulus();
    release dut.frame_cnt;
    applyStimulus();
    checkOutput("wrap_preset", {16'd0, frame_cnt}, 32'hFFFE);
    agc_n = 1'b1; dly = 8'd0; mag = 32'd300; thr = 32'd200; corr_vld = 1'b1;
    start = 1'b1;
    waitState(3'd5, 40, "wrap_done1");
    checkOutput("wrap_cnt_ffff", {16'd0, frame_cnt}, 32'hFFFF);
    applyStimulus();
    checkOutput("rearm_search", {29'd0, state}, 32'd2);
    checkOutput("rearm_busy", {31'd0, busy}, 32'd1);
    waitState(3'd5, 40, "wrap_done2");
    checkOutput("wrap_cnt_0000", {16'd0, frame_cnt}, 32'h0000);
    start = 1'b0; corr_vld = 1'b0;
    applyStimulus();
    checkOutput("wrap_idle", {29'd0, state}, 32'd0);

    // Table-driven whole frames
    for (int i = 0; i < NV; i++) begin
      agc_n = vecs[i].agc_n; mag = vecs[i].mag; thr = vecs[i].thr; dly = vecs[i].dly;
      corr_vld = 1'b0; start = 1'b0;
      applyStimulus();
      fc0 = frame_cnt;
      clearStats();
      start = 1'b1;
      finished = 1'b0;
      for (int c = 0; c < 400 && !finished; c++) begin
        corr_vld = (state == 3'd2) && (cnt[2] >= 2) && !sym_vld;
        applyStimulus();
        if (done) start = 1'b0;
        if (state == 3'd0) finished = 1'b1;
      end
      corr_vld = 1'b0; start = 1'b0;
      checkOutput($sformatf("vec%0d_back_to_idle", i), {31'd0, finished}, 32'd1);
      checkOutput($sformatf("vec%0d_state_mask", i), {24'd0, mask}, {24'd0, vecs[i].exp_mask});
      checkOutput($sformatf("vec%0d_agc_syms", i), cnt[1], vecs[i].exp_agc);
      checkOutput($sformatf("vec%0d_search_syms", i), cnt[2], vecs[i].exp_search);
      checkOutput($sformatf("vec%0d_delay_syms", i), cnt[3], vecs[i].exp_delay);
      checkOutput($sformatf("vec%0d_store_en_syms", i), store_en_syms, vecs[i].exp_store);
      checkOutput($sformatf("vec%0d_done_pulses", i), n_done, vecs[i].exp_done);
      checkOutput($sformatf("vec%0d_timeout_pulses", i), n_timeout, vecs[i].exp_to);
      checkOutput($sformatf("vec%0d_frame_delta", i), {16'd0, frame_cnt - fc0}, vecs[i].exp_fc);
      checkOutput($sformatf("vec%0d_agc_en_seen", i), {31'd0, agc_seen}, {31'd0, vecs[i].exp_agc_en});
      checkOutput($sformatf("vec%0d_idle_busy", i), {31'd0, busy}, 32'd0);
    end

    // Abort during STORE after 3 valid samples
    agc_n = 1'b1; dly = 8'd0; mag = 32'd300; thr = 32'd200; corr_vld = 1'b0; start = 1'b0;
    applyStimulus();
    fc0 = frame_cnt;
    start = 1'b1;
    waitState(3'd2, 4, "abort_enter_search");
    corr_vld = 1'b1;
    applyStimulus();
    corr_vld = 1'b0;
    checkOutput("abort_enter_store", {29'd0, state}, 32'd4);
    clearStats();
    for (int c = 0; c < 20 && cnt[4] < 3; c++) applyStimulus();
    checkOutput("abort_store_syms", cnt[4], 32'd3);
    start = 1'b0;
    applyStimulus();
    checkOutput("abort_idle", {29'd0, state}, 32'd0);
    checkOutput("abort_store_en_low", {31'd0, store_en}, 32'd0);
    checkOutput("abort_no_done", n_done, 32'd0);
    checkOutput("abort_frame_cnt", {16'd0, frame_cnt}, {16'd0, fc0});

    // Detect on the same cycle as the 20th valid sample in SEARCH
    agc_n = 1'b1; dly = 8'd2; mag = 32'd300; thr = 32'd200; corr_vld = 1'b0;
    applyStimulus();
    start = 1'b1;
    waitState(3'd2, 4, "sim_enter_search");
    clearStats();
    for (int c = 0; c < 100 && !(cnt[2] == 19 && sym_vld); c++) applyStimulus();
    checkOutput("sim_search_syms", cnt[2], 32'd19);
    corr_vld = 1'b1;
    applyStimulus();
    corr_vld = 1'b0;
    checkOutput("sim_delay", {29'd0, state}, 32'd3);
    checkOutput("sim_no_timeout", n_timeout, 32'd0);

    // Reset during DELAY with i_start held high
    rst = 1'b1;
    applyStimulus();
    checkOutput("dly_rst_state", {29'd0, state}, 32'd0);
    checkOutput("dly_rst_flags", {26'd0, agc_en, corr_arm, store_en, busy, done, timeout}, 32'd0);
    checkOutput("dly_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) applyStimulus();
    checkOutput("dly_rst_no_rearm", {29'd0, state}, 32'd0);
    start = 1'b0;
    applyStimulus();
    start = 1'b1;
    applyStimulus();
    checkOutput("dly_rst_rearm", {29'd0, state}, 32'd2);
    start = 1'b0;
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
